// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side load/store sequencer driving a word-wide data memory port
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       write_data,
  input  logic [31:0]       read_data
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t              state;
  logic                we;
  logic                uns;
  logic [1:0]          size;
  logic [ADDR_W-1:0]   addr;
  logic [31:0]         wdata;
  logic [31:0]         buffer;
  logic                misaligned;
  logic [4:0]          bsh;
  logic [4:0]          hsh;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         merged;
  logic [31:0]         load_data;
  assign req_ready  = state == IDLE;
  assign mem_read   = state == READ;
  assign mem_write  = state == WRITE;
  assign resp_valid = state == RESP;
  assign address    = {addr[ADDR_W-1:2], 2'b00};
  assign write_data = mem_write ? merged : 32'h0;
  assign bsh        = {addr[1:0], 3'b000};
  assign hsh        = {addr[1], 4'b0000};
  assign lane_b     = read_data[bsh +: 8];
  assign lane_h     = read_data[hsh +: 16];
  // Alignment of the incoming request decides whether memory is touched at all
  always_comb
    misaligned = req_size == 2'b01 ? req_addr[0] : req_size[1] ? |req_addr[1:0] : 1'b0;
  // Lane merge for sub-word stores over the word fetched in READ; word stores pass through
  always_comb
    merged = size == 2'b00 ? (buffer & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata[7:0]} << bsh)
           : size == 2'b01 ? (buffer & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata[15:0]} << hsh)
           : wdata;
  // Lane extraction and extension taken straight off the memory bus during READ
  always_comb
    load_data = size == 2'b00 ? {{24{~uns & lane_b[7]}}, lane_b}
              : size == 2'b01 ? {{16{~uns & lane_h[15]}}, lane_h}
              : read_data;
  // Request sequencer: latch on accept, optional read, optional write, one-cycle response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      we         <= 1'b0;
      uns        <= 1'b0;
      size       <= 2'b00;
      addr       <= '0;
      wdata      <= 32'h0;
      buffer     <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we         <= req_we;
          uns        <= req_unsigned;
          size       <= req_size;
          addr       <= req_addr;
          wdata      <= req_wdata;
          resp_rdata <= 32'h0;
          resp_err   <= misaligned;
          state      <= misaligned ? RESP : !req_we ? READ : req_size[1] ? WRITE : READ;
        end
        READ: begin
          buffer     <= read_data;
          resp_rdata <= we ? 32'h0 : load_data;
          state      <= we ? WRITE : RESP;
        end
        WRITE: state <= RESP;
        default: begin
          resp_rdata <= 32'h0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
endmodule
